bcd_press_counter: RTL and testbench
====================================

Name: bcd_press_counter

Overview:
- Downstream consumer of the push-button detector's one-cycle pulses (z).
- Keeps a 4-digit BCD event count with increment, decrement and clear.
- Drives a time-multiplexed, active-low 4-digit 7-segment display.
- Sits between the button-detector stage and the board display pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is lit before the scan advances; legal range 2 or more.
- BLANK_LEADING, 1: 1 blanks leading zeros on digits 3..1; 0 shows all digits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- inc  input  1  one-cycle increment pulse from the push-button detector z.
- dec  input  1  one-cycle decrement pulse from a second detector.
- clr  input  1  synchronous clear of the count; level-sensitive.
- count_bcd  output  16  current count; digit3 is [15:12], digit0 is [3:0].
- anode  output  4  active-low digit select, one-hot low.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset is asynchronous, active-high. While reset is high:
  - count_bcd = 16'h0000; scan index = 0; refresh counter = 0.
  - anode = 4'b1110; seg = 7'b1000000 (glyph "0").
- Count update priority each clock: clr, then (inc XOR dec), then hold.
  - clr=1: count becomes 0000 next edge; inc and dec are ignored.
  - inc=1, dec=0: +1 in BCD with digit-wise carry; 9999 -> 0000 (wrap).
  - dec=1, inc=0: -1 in BCD with digit-wise borrow; 0000 -> 9999 (wrap).
  - inc=dec=1 in the same cycle: no change.
- Count latency: a pulse sampled high at edge N gives the new count_bcd after edge N. No input registering is done; inputs are synchronous single-cycle pulses.
- A pulse longer than one cycle counts once per cycle high. Edge detection is the upstream stage's job.
- Each BCD digit is always in the range 0..9. Non-decimal nibbles are unreachable.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - At terminal count, scan index advances 0->1->2->3->0.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- anode and seg are registered. They are computed from the current scan index and current count, so they lag both by one cycle.
  - Scan index i drives anode bit i low; all other anode bits are high.
- Glyphs, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k (k = 3..1) is blanked (seg = 7'b1111111) when it and every higher digit are zero.
  - Digit 0 is never blanked.
  - The anode is still driven while a digit is blanked.
- A count change mid-scan shows on the next registered seg update. There is no tearing protection.
- Reset asserted mid-operation clears all state immediately. Counting resumes on the first edge after reset deasserts.

Test Plan (bench uses REFRESH_DIV=4):
- Reset release, no pulses -> count_bcd=0000; anode cycles 1110,1101,1011,0111, 4 cycles each; seg on digit0 = 1000000; seg on digits 1-3 = 1111111.
- 10 inc pulses -> count_bcd=0010; digit1 seg=1111001; digit0 seg=1000000; digits 2-3 blank.
- Load 0999 via 999 pulses, then one inc -> 1000 (triple carry). From 9999, one inc -> 0000.
- From 0000, one dec -> 9999. From 1000, one dec -> 0999.
- inc and dec high together -> no change. clr with inc in the same cycle -> 0000.
- Reset asserted asynchronously between clock edges with count 0042 -> count_bcd=0000 and anode=1110 immediately, before the next edge.

Source files
------------

// File: rtl/bcd_press_counter.sv
// bcd_press_counter
//   Four-digit BCD event counter driven by one-cycle pulses from upstream
//   push-button detectors, with a time-multiplexed, active-low 4-digit
//   7-segment display driver.
//
// Parameters
//   REFRESH_DIV   : clock cycles each digit stays lit before the scan advances (>= 2)
//   BLANK_LEADING : 1 blanks leading zeros on digits 3..1, 0 shows every digit
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   inc       : +1 pulse (one cycle per count)
//   dec       : -1 pulse (one cycle per count)
//   clr       : synchronous clear, highest priority
//   count_bcd : current count, digit3 in [15:12] .. digit0 in [3:0]
//   anode     : active-low digit select, one-hot low
//   seg       : active-low segments {g,f,e,d,c,b,a}
module bcd_press_counter #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        dec,
  input  logic        clr,
  output logic [15:0] count_bcd,
  output logic [3:0]  anode,
  output logic [6:0]  seg
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [15:0]   r_count;
  logic [RW-1:0] r_refresh;
  logic [1:0]    r_scan;
  logic [3:0]    r_anode;
  logic [6:0]    r_seg;

  logic [15:0] w_count_inc;
  logic [15:0] w_count_dec;
  logic        w_carry;
  logic        w_borrow;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_glyph;
  logic [3:0]  w_anode;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Digit-wise ripple: a digit rolls over only while every lower digit rolled.
  always_comb begin
    w_count_inc = r_count;
    w_count_dec = r_count;
    w_carry     = 1'b1;
    w_borrow    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_count[i*4 +: 4] == 4'd9) begin
          w_count_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_count_inc[i*4 +: 4] = r_count[i*4 +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_count[i*4 +: 4] == 4'd0) begin
          w_count_dec[i*4 +: 4] = 4'd9;
        end else begin
          w_count_dec[i*4 +: 4] = r_count[i*4 +: 4] - 4'd1;
          w_borrow = 1'b0;
        end
      end
    end
  end

  // Blank a non-zero digit position when it and everything above it is zero,
  // i.e. the count shifted down to this digit is zero.
  always_comb begin
    w_digit = r_count[{r_scan, 2'b00} +: 4];
    w_blank = (BLANK_LEADING != 0) && (r_scan != 2'd0) &&
              ((r_count >> {r_scan, 2'b00}) == 16'd0);
    w_glyph = w_blank ? 7'b1111111 : glyph(w_digit);
    w_anode = 4'b1111;
    w_anode[r_scan] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 16'h0000;
    end else if (clr) begin
      r_count <= 16'h0000;
    end else if (inc && !dec) begin
      r_count <= w_count_inc;
    end else if (dec && !inc) begin
      r_count <= w_count_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_scan    <= 2'd0;
    end else if (r_refresh == REFRESH_LAST) begin
      r_refresh <= '0;
      r_scan    <= r_scan + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Display outputs are registered from the current scan/count, one cycle behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anode <= 4'b1110;
      r_seg   <= 7'b1000000;
    end else begin
      r_anode <= w_anode;
      r_seg   <= w_glyph;
    end
  end

  assign count_bcd = r_count;
  assign anode     = r_anode;
  assign seg       = r_seg;

endmodule

// File: tb/tb_bcd_press_counter.sv
module tb_bcd_press_counter;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic        inc;
  logic        dec;
  logic        clr;
  logic [15:0] count_bcd;
  logic [3:0]  anode;
  logic [6:0]  seg;

  bcd_press_counter #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clr(clr),
    .count_bcd(count_bcd), .anode(anode), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: decimal count and number of edges since reset release.
  int m_count;
  int m_edges;
  logic [15:0] exp_count;
  logic [3:0]  exp_anode;
  logic [6:0]  exp_seg;

  logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input int c, input int idx);
    int p;
    p = 1;
    for (int j = 0; j < idx; j++) p = p * 10;
    if (idx > 0 && (c / p) == 0) return 7'b1111111;
    return GLYPH[(c / p) % 10];
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample at edge+1.
  task automatic step(input bit i_inc, input bit i_dec, input bit i_clr);
    int idx;
    int prev;
    inc = i_inc; dec = i_dec; clr = i_clr;
    @(posedge clk);
    idx  = (m_edges / DIV) % 4;
    prev = m_count;
    if (i_clr) m_count = 0;
    else if (i_inc && !i_dec) m_count = (m_count + 1) % 10000;
    else if (i_dec && !i_inc) m_count = (m_count + 9999) % 10000;
    m_edges++;
    exp_count = to_bcd(m_count);
    exp_anode = 4'b1111;
    exp_anode[idx] = 1'b0;
    exp_seg = model_seg(prev, idx);
    #1;
  endtask

  task automatic do_reset();
    inc = 0; dec = 0; clr = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = 0;
    m_edges = 0;
  endtask

  task automatic test_reset();
    inc = 0; dec = 0; clr = 0;
    reset = 1'b1;
    #12;
    n_tests++;
    if (count_bcd !== 16'h0000 || anode !== 4'b1110 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_state: count=%h anode=%b seg=%b required 0000 1110 1000000",
               count_bcd, anode, seg);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = 0; m_edges = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 0);
      n_tests++;
      if (count_bcd !== exp_count || anode !== exp_anode || seg !== exp_seg) begin
        n_fail++;
        $display("FAIL idle_scan[%0d]: count=%h anode=%b seg=%b required %h %b %b",
                 c, count_bcd, anode, seg, exp_count, exp_anode, exp_seg);
      end
    end
  endtask

  task automatic test_inc10();
    do_reset();
    for (int c = 0; c < 10; c++) step(1, 0, 0);
    n_tests++;
    if (count_bcd !== 16'h0010) begin
      n_fail++;
      $display("FAIL inc10_count: got %h required 0010", count_bcd);
    end
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 0);
      n_tests++;
      if (count_bcd !== exp_count || anode !== exp_anode || seg !== exp_seg) begin
        n_fail++;
        $display("FAIL inc10_scan[%0d]: count=%h anode=%b seg=%b required %h %b %b",
                 c, count_bcd, anode, seg, exp_count, exp_anode, exp_seg);
      end
    end
  endtask

  task automatic test_carry_wrap();
    step(0, 0, 1);
    for (int c = 0; c < 999; c++) begin
      step(1, 0, 0);
      n_tests++;
      if (count_bcd !== exp_count) begin
        n_fail++;
        $display("FAIL load_count[%0d]: got %h required %h", c, count_bcd, exp_count);
      end
    end
    step(1, 0, 0);
    n_tests++;
    if (count_bcd !== 16'h1000) begin
      n_fail++;
      $display("FAIL triple_carry: got %h required 1000", count_bcd);
    end
    step(0, 1, 0);
    n_tests++;
    if (count_bcd !== 16'h0999) begin
      n_fail++;
      $display("FAIL triple_borrow: got %h required 0999", count_bcd);
    end
    step(0, 0, 1);
    step(0, 1, 0);
    n_tests++;
    if (count_bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL dec_wrap: got %h required 9999", count_bcd);
    end
    step(1, 0, 0);
    n_tests++;
    if (count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL inc_wrap: got %h required 0000", count_bcd);
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 7; c++) step(1, 0, 0);
    step(1, 1, 0);
    n_tests++;
    if (count_bcd !== 16'h0007) begin
      n_fail++;
      $display("FAIL inc_dec_hold: got %h required 0007", count_bcd);
    end
    step(1, 0, 1);
    n_tests++;
    if (count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL clr_priority: got %h required 0000", count_bcd);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 42; c++) step(1, 0, 0);
    step(0, 0, 0);
    n_tests++;
    if (count_bcd !== 16'h0042) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %h required 0042", count_bcd);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (count_bcd !== 16'h0000 || anode !== 4'b1110 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL async_reset: count=%h anode=%b seg=%b required 0000 1110 1000000",
               count_bcd, anode, seg);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = 0; m_edges = 0;
    step(1, 0, 0);
    n_tests++;
    if (count_bcd !== 16'h0001) begin
      n_fail++;
      $display("FAIL resume_after_reset: got %h required 0001", count_bcd);
    end
  endtask

  task automatic test_random();
    bit r_i, r_d, r_c;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r_i = 1'($urandom_range(0, 1));
      r_d = 1'($urandom_range(0, 1));
      r_c = ($urandom_range(0, 39) == 0);
      step(r_i, r_d, r_c);
      n_tests++;
      if (count_bcd !== exp_count || anode !== exp_anode || seg !== exp_seg) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%h anode=%b seg=%b required %h %b %b",
                 c, count_bcd, anode, seg, exp_count, exp_anode, exp_seg);
      end
    end
  endtask

  initial begin
    reset = 1'b0; inc = 0; dec = 0; clr = 0;
    m_count = 0; m_edges = 0;
    test_reset();
    test_inc10();
    test_carry_wrap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
